// File: rtl/nios_gpio_pkg.sv
// rtl/nios_gpio_pkg.sv - shared constants for the Nios input PIO
package nios_gpio_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/gpio_sync_edge.sv
// rtl/gpio_sync_edge.sv - input synchronizer, previous-sample register and warm-up gated edge detect
module gpio_sync_edge
    import nios_gpio_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = EDGE_RISING
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] sync_data,
    output logic [WIDTH-1:0] edge_pulse
);

    localparam int             CW   = $clog2(SYNC_STAGES + 2);
    localparam logic [CW-1:0]  WARM = CW'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] prev_q;
    logic [CW-1:0]    warm_cnt;
    logic [WIDTH-1:0] raw_edge;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            prev_q   <= '0;
            warm_cnt <= '0;
        end else begin
            sync_q[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[SYNC_STAGES-1];
            if (warm_cnt != WARM) begin
                warm_cnt <= warm_cnt + 1'b1;
            end
        end
    end

    assign sync_data = sync_q[SYNC_STAGES-1];

    if (EDGE_TYPE == EDGE_FALLING) begin : g_falling
        assign raw_edge = ~sync_data & prev_q;
    end else if (EDGE_TYPE == EDGE_ANY) begin : g_any
        assign raw_edge = sync_data ^ prev_q;
    end else begin : g_rising
        assign raw_edge = sync_data & ~prev_q;
    end

    // Until the chain and prev register hold real samples, an already-high input would look like an edge
    assign edge_pulse = (warm_cnt == WARM) ? raw_edge : '0;

endmodule

// File: rtl/nios_gpio_in.sv
// rtl/nios_gpio_in.sv - Avalon-MM input PIO with edge capture and masked level interrupt
module nios_gpio_in
    import nios_gpio_pkg::*;
#(
    parameter int          WIDTH       = 32,
    parameter int          SYNC_STAGES = 2,
    parameter int          EDGE_TYPE   = EDGE_RISING,
    parameter logic [31:0] RESET_MASK  = 32'h0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $fatal(1, "nios_gpio_in: WIDTH must be 1..32");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $fatal(1, "nios_gpio_in: SYNC_STAGES must be at least 2");
    end

    logic [WIDTH-1:0] sync_data;
    logic [WIDTH-1:0] edge_pulse;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] irq_mask;
    logic             wr_en;

    assign wr_en = chipselect && !write_n;

    gpio_sync_edge #(
        .WIDTH      (WIDTH),
        .SYNC_STAGES(SYNC_STAGES),
        .EDGE_TYPE  (EDGE_TYPE)
    ) u_sync_edge (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_port   (in_port),
        .sync_data (sync_data),
        .edge_pulse(edge_pulse)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            edge_cap <= '0;
            irq_mask <= RESET_MASK[WIDTH-1:0];
            irq      <= 1'b0;
        end else begin
            if (wr_en && address == ADDR_MASK) begin
                irq_mask <= writedata[WIDTH-1:0];
            end
            // New edges are OR-ed in after the clear so a same-cycle set survives
            if (wr_en && address == ADDR_EDGE) begin
                edge_cap <= (edge_cap & ~writedata[WIDTH-1:0]) | edge_pulse;
            end else begin
                edge_cap <= edge_cap | edge_pulse;
            end
            irq <= |(edge_cap & irq_mask);
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA: readdata[WIDTH-1:0] = sync_data;
            ADDR_MASK: readdata[WIDTH-1:0] = irq_mask;
            ADDR_EDGE: readdata[WIDTH-1:0] = edge_cap;
            default:   readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_nios_gpio_in.sv
// tb/tb_nios_gpio_in.sv - scoreboard bench for nios_gpio_in (32-bit rising and 8-bit any-edge instances)
module tb_nios_gpio_in;
    import nios_gpio_pkg::*;

    localparam int SS0 = 2;
    localparam int SS1 = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'h0;
    logic [31:0] in_port = 32'h0;
    logic [31:0] rd0, rd1;
    logic        irq0, irq1;

    always #5 clk = ~clk;

    nios_gpio_in #(.WIDTH(32), .SYNC_STAGES(SS0), .EDGE_TYPE(EDGE_RISING), .RESET_MASK(32'h0)) dut0 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd0), .in_port(in_port), .irq(irq0));

    nios_gpio_in #(.WIDTH(8), .SYNC_STAGES(SS1), .EDGE_TYPE(EDGE_ANY), .RESET_MASK(32'h0F)) dut1 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd1), .in_port(in_port[7:0]), .irq(irq1));

    // Reference: history of sampled inputs, DATA is the sample SS edges old
    int          ss    [2] = '{SS0, SS1};
    int          et    [2] = '{0, 2};
    logic [31:0] wm    [2] = '{32'hFFFF_FFFF, 32'h0000_00FF};
    logic [31:0] rmask [2] = '{32'h0, 32'h0F};
    logic [31:0] hist  [2][8];
    logic [31:0] cap   [2];
    logic [31:0] msk   [2];
    logic        irq_m [2];
    int          nedge [2];
    bit          model_ok = 0;

    typedef struct {
        logic [31:0] rd0;
        logic [31:0] rd1;
        logic        irq0;
        logic        irq1;
    } exp_t;
    exp_t sb[$];

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] cur_in = 32'h0;

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            logic [31:0] s, p, det;
            if (!reset_n) begin
                cap[i] = 32'h0; msk[i] = rmask[i]; irq_m[i] = 1'b0; nedge[i] = 0;
                for (int k = 0; k < 8; k++) hist[i][k] = 32'h0;
            end else begin
                s = hist[i][ss[i]-1];
                p = hist[i][ss[i]];
                det = (et[i] == 0) ? (s & ~p) : (et[i] == 1) ? (~s & p) : (s ^ p);
                if (nedge[i] < ss[i] + 1) det = 32'h0;
                irq_m[i] = |(cap[i] & msk[i]);
                if (chipselect && !write_n && address == ADDR_EDGE) cap[i] = cap[i] & ~writedata;
                cap[i] = (cap[i] | det) & wm[i];
                if (chipselect && !write_n && address == ADDR_MASK) msk[i] = writedata & wm[i];
                for (int k = 7; k > 0; k--) hist[i][k] = hist[i][k-1];
                hist[i][0] = in_port & wm[i];
                if (nedge[i] < 100) nedge[i]++;
            end
        end
        model_ok = 1;
    endtask

    function automatic logic [31:0] exp_rd(int i, logic [1:0] a);
        case (a)
            ADDR_DATA: return hist[i][ss[i]-1];
            ADDR_MASK: return msk[i];
            ADDR_EDGE: return cap[i];
            default:   return 32'h0;
        endcase
    endfunction

    task automatic cyc(input logic rn, input logic [1:0] a, input logic wr,
                       input logic [31:0] wd, input logic [31:0] inp);
        exp_t e;
        reset_n    = rn;
        address    = a;
        chipselect = wr | 1'($urandom_range(0, 1));
        write_n    = !wr;
        writedata  = wd;
        in_port    = inp;
        if (model_ok) begin
            e.rd0 = exp_rd(0, a); e.rd1 = exp_rd(1, a);
            e.irq0 = irq_m[0];    e.irq1 = irq_m[1];
            sb.push_back(e);
        end
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 2'(i), 1'b0, $urandom, cur_in);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            if (n_bad <= 20) $display("FAIL %s at %0t: got %h required %h", nm, $time, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("rd32", rd0, e.rd0);
            chk("irq32", {31'h0, irq0}, {31'h0, e.irq0});
            chk("rd8", rd1, e.rd1);
            chk("irq8", {31'h0, irq1}, {31'h0, e.irq1});
        end
    end

    initial begin
        #1;
        // Reset with all inputs high; warm-up must hide the apparent edge
        cur_in = 32'hFFFF_FFFF;
        repeat (2) cyc(1'b0, ADDR_EDGE, 1'b0, 32'h0, cur_in);
        idle(12);
        // Drop inputs (any-edge instance captures), clear, then rising edge on bit5
        cur_in = 32'h0;
        idle(6);
        cyc(1'b1, ADDR_EDGE, 1'b1, 32'hFFFF_FFFF, cur_in);
        cur_in = 32'h20;
        for (int i = 0; i < 6; i++) cyc(1'b1, (i % 2) ? ADDR_EDGE : ADDR_DATA, 1'b0, 32'h0, cur_in);
        // Mask bit5 -> irq, then clear capture -> irq drops
        cyc(1'b1, ADDR_MASK, 1'b1, 32'h20, cur_in);
        repeat (3) cyc(1'b1, ADDR_EDGE, 1'b0, 32'h0, cur_in);
        cyc(1'b1, ADDR_EDGE, 1'b1, 32'h20, cur_in);
        repeat (3) cyc(1'b1, ADDR_EDGE, 1'b0, 32'h0, cur_in);
        // Clear of bit3 in the very cycle its rising edge is detected
        cur_in = 32'h28;
        cyc(1'b1, ADDR_EDGE, 1'b0, 32'h0, cur_in);
        cyc(1'b1, ADDR_EDGE, 1'b0, 32'h0, cur_in);
        cyc(1'b1, ADDR_EDGE, 1'b1, 32'h8, cur_in);
        cyc(1'b1, ADDR_EDGE, 1'b1, 32'h8, cur_in);
        repeat (3) cyc(1'b1, ADDR_EDGE, 1'b0, 32'h0, cur_in);
        // Three-cycle pulse on bit0, plus reads of the reserved word
        cyc(1'b1, ADDR_EDGE, 1'b1, 32'hFF, cur_in);
        for (int i = 0; i < 3; i++) cyc(1'b1, 2'd1, 1'b0, 32'h0, cur_in | 32'h1);
        for (int i = 0; i < 8; i++) cyc(1'b1, (i % 2) ? ADDR_EDGE : 2'd1, 1'b1 & (i == 0), 32'hFFFF_FFFF, cur_in);
        // Fill captures and mask, then a one-cycle reset
        cyc(1'b1, ADDR_MASK, 1'b1, 32'hFF, cur_in);
        cur_in = 32'hFF;
        idle(6);
        cur_in = 32'h0;
        idle(6);
        cyc(1'b0, ADDR_EDGE, 1'b1, 32'hFFFF_FFFF, cur_in);
        for (int i = 0; i < 6; i++) cyc(1'b1, (i % 2) ? ADDR_MASK : ADDR_EDGE, 1'b0, 32'h0, cur_in);
        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            logic rn;
            logic wr;
            rn = ($urandom_range(0, 99) != 0);
            wr = ($urandom_range(0, 3) == 0);
            cur_in = cur_in ^ ($urandom & $urandom & $urandom);
            cyc(rn, 2'($urandom_range(0, 3)), wr, $urandom, cur_in);
        end
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
